reg_pipeline: RTL

//   Parametrised D-register pipeline: WIDTH-bit data through DEPTH register stages with valid/ready flow control.

---
 rtl/reg_pipeline_if.sv | 26 ++
 rtl/reg_pipeline.sv | 77 +++++++
 2 files changed

// File: rtl/reg_pipeline_if.sv
// Handshake bundle for reg_pipeline: upstream valid/ready/data, downstream valid/ready/data, occupancy.
// master = the surrounding logic that feeds and drains the pipe; slave = the pipe itself.
interface reg_pipeline_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/reg_pipeline.sv
// WIDTH-bit, DEPTH-stage register pipeline with valid/ready flow control,
// bubble collapse, configurable reset value and a registered occupancy count.
module reg_pipeline #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               CLR_DATA    = 1'b1
) (
  input  logic          clk,
  input  logic          async_reset,
  input  logic          sync_reset,
  reg_pipeline_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] go;
  logic [OCC_W-1:0] occ;
  logic             in_fire;
  logic             out_fire;

  // A stage may advance if it is empty or everything downstream of it advances.
  // Built as a running OR from the output back so no bit depends on another bit of go.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    logic chain;
    chain = bus.out_ready;
    go    = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      chain = chain | ~v[k];
      go[k] = chain;
    end
  end

  assign bus.in_ready  = go[0] & ~sync_reset & ~async_reset;
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = v[DEPTH-1] & bus.out_ready;

  assign bus.out_valid = v[DEPTH-1];
  assign bus.out_data  = d[DEPTH-1];
  assign bus.occupancy = occ;

  // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
  // NOTE: the data registers are deliberately reset, because out_data must read RESET_VALUE during reset.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      v   <= '0;
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VALUE;
    end else if (sync_reset) begin
      v   <= '0;
      occ <= '0;
      if (CLR_DATA) begin
        for (int k = 0; k < DEPTH; k++) d[k] <= RESET_VALUE;
      end
    end else begin
      if (go[0]) begin
        v[0] <= in_fire;
        if (in_fire) d[0] <= bus.in_data;
      end
      // Data only moves behind a valid bit; empty slots keep their old contents.
      for (int k = 1; k < DEPTH; k++) begin
        if (go[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) d[k] <= d[k-1];
        end
      end

      if (in_fire && !out_fire) begin
        occ <= occ + OCC_W'(1);
      end else if (!in_fire && out_fire) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end
endmodule
